// File: rtl/simon_stream_if.sv
// -----------------------------------------------------------------------------
// simon_stream_if
//   Byte-stream front end for the SIMON iterative encryption core. Key and
//   plaintext words arrive on a narrow valid/ready stream and are packed
//   little-endian into wide registers. The block then runs the core's
//   newData/readData handshake, captures the ciphertext and serialises it,
//   low word first, onto a valid/ready output stream.
//
// Ports
//   clk, nR            clock (rising edge), asynchronous active-low reset
//   din/dinKey/dinValid/dinReady   input stream (dinKey=1: key word)
//   dout/doutValid/doutReady       ciphertext output stream
//   keyErr             sticky: key word accepted after the core stored a key
//   busy               high in every state except IDLE
//   newData/readData   start request / result consumed, to the core
//   plain/key          plaintext and key to the core (key[0] = first round key)
//   doneData/doneKey/cipher        status and result from the core
// -----------------------------------------------------------------------------
module simon_stream_if #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 32,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             nR,
    input  logic [W-1:0]     din,
    input  logic             dinKey,
    input  logic             dinValid,
    output logic             dinReady,
    output logic [W-1:0]     dout,
    output logic             doutValid,
    input  logic             doutReady,
    output logic             keyErr,
    output logic             busy,
    output logic             newData,
    output logic             readData,
    output logic [2*N-1:0]   plain,
    output logic [M*N-1:0]   key,
    input  logic             doneData,
    input  logic             doneKey,
    input  logic [2*N-1:0]   cipher
);

    localparam int KEY_WORDS = (M * N) / W;
    localparam int PT_WORDS  = (2 * N) / W;
    localparam int KCW       = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int PCW       = (PT_WORDS > 1) ? $clog2(PT_WORDS) : 1;
    localparam logic [KCW-1:0] KEY_LAST = KCW'(KEY_WORDS - 1);
    localparam logic [PCW-1:0] PT_LAST  = PCW'(PT_WORDS - 1);

    // T only matters for the core's latency; here it is just sanity-checked.
    if ((T < 1) || (((2 * N) % W) != 0) || (((M * N) % W) != 0)) begin : g_bad_params
        $error("simon_stream_if: illegal parameter set");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, RUN, CAPT, SEND} state_e;

    state_e           state_q, state_d;
    logic [KCW-1:0]   key_cnt_q, key_cnt_d;
    logic [PCW-1:0]   plain_cnt_q, plain_cnt_d;
    logic [PCW-1:0]   out_cnt_q, out_cnt_d;
    logic             key_loaded_q, key_loaded_d;
    logic             key_err_q, key_err_d;
    logic [M*N-1:0]   key_q, key_d;
    logic [2*N-1:0]   plain_q, plain_d;
    logic [2*N-1:0]   ciph_q, ciph_d;
    logic             din_acc;

    assign din_acc = dinValid & dinReady;

    // ---------------- FSM: state register ----------------
    // NOTE: clocked processes use non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (din_acc && !dinKey && plain_cnt_q == PT_LAST) state_d = ISSUE;
            ISSUE: state_d = ARM;
            // A stale doneData from the previous run must drop before RUN,
            // otherwise the old ciphertext would be captured.
            ARM:   if (!doneData) state_d = RUN;
            RUN:   if (doneData) state_d = CAPT;
            CAPT:  state_d = SEND;
            SEND:  if (doutReady && out_cnt_q == PT_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        dinReady  = 1'b0;
        newData   = 1'b0;
        readData  = 1'b0;
        doutValid = 1'b0;
        unique case (state_q)
            // Key and plaintext loads never interleave; plaintext also
            // waits until a complete key has been loaded.
            IDLE:  dinReady = (dinKey && plain_cnt_q == '0) ||
                              (!dinKey && key_cnt_q == '0 && key_loaded_q);
            ISSUE: newData   = 1'b1;
            CAPT:  readData  = 1'b1;
            SEND:  doutValid = 1'b1;
            default: ;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign dout   = ciph_q[W-1:0];
    assign plain  = plain_q;
    assign key    = key_q;
    assign keyErr = key_err_q;

    // ---------------- datapath next state ----------------
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        key_d        = key_q;
        plain_d      = plain_q;
        ciph_d       = ciph_q;
        key_cnt_d    = key_cnt_q;
        plain_cnt_d  = plain_cnt_q;
        out_cnt_d    = out_cnt_q;
        key_loaded_d = key_loaded_q;
        key_err_d    = key_err_q;
        unique case (state_q)
            IDLE: begin
                if (din_acc && dinKey) begin
                    key_d[int'(key_cnt_q) * W +: W] = din;
                    // The core keeps its first key schedule; flag the attempt.
                    if (doneKey) key_err_d = 1'b1;
                    if (key_cnt_q == KEY_LAST) begin
                        key_cnt_d    = '0;
                        key_loaded_d = 1'b1;
                    end else begin
                        key_cnt_d = key_cnt_q + KCW'(1);
                    end
                end else if (din_acc) begin
                    plain_d[int'(plain_cnt_q) * W +: W] = din;
                    plain_cnt_d = (plain_cnt_q == PT_LAST) ? '0 : plain_cnt_q + PCW'(1);
                end
            end
            RUN: if (doneData) ciph_d = cipher;
            SEND: begin
                if (doutReady) begin
                    ciph_d    = ciph_q >> W;
                    out_cnt_d = (out_cnt_q == PT_LAST) ? '0 : out_cnt_q + PCW'(1);
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    // NOTE: the wide data registers are reset as well: a reset shared with
    // the core must discard partial key/plaintext and leave outputs at 0.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            key_q        <= '0;
            plain_q      <= '0;
            ciph_q       <= '0;
            key_cnt_q    <= '0;
            plain_cnt_q  <= '0;
            out_cnt_q    <= '0;
            key_loaded_q <= 1'b0;
            key_err_q    <= 1'b0;
        end else begin
            key_q        <= key_d;
            plain_q      <= plain_d;
            ciph_q       <= ciph_d;
            key_cnt_q    <= key_cnt_d;
            plain_cnt_q  <= plain_cnt_d;
            out_cnt_q    <= out_cnt_d;
            key_loaded_q <= key_loaded_d;
            key_err_q    <= key_err_d;
        end
    end

endmodule

// File: tb/tb_simon_stream_if.sv
// -----------------------------------------------------------------------------
// tb_simon_stream_if
//   Drives simon_stream_if with byte streams, emulates the SIMON core it talks
//   to (handshake timing plus a SIMON32/64 reference cipher) and compares the
//   serialised ciphertext, pulse counts and latency against its own model.
// -----------------------------------------------------------------------------
module tb_simon_stream_if;

    localparam int N  = 16;
    localparam int M  = 4;
    localparam int T  = 32;
    localparam int W  = 8;
    localparam int PW = (2 * N) / W;
    localparam int KW = (M * N) / W;

    logic          clk = 1'b0;
    logic          nR;
    logic [W-1:0]  din;
    logic          dinKey, dinValid, dinReady;
    logic [W-1:0]  dout;
    logic          doutValid, doutReady;
    logic          keyErr, busy, newData, readData;
    logic [2*N-1:0] plain;
    logic [M*N-1:0] key;
    logic          doneData, doneKey;
    logic [2*N-1:0] cipher;

    simon_stream_if #(.N(N), .M(M), .T(T), .W(W)) dut (
        .clk(clk), .nR(nR), .din(din), .dinKey(dinKey), .dinValid(dinValid),
        .dinReady(dinReady), .dout(dout), .doutValid(doutValid),
        .doutReady(doutReady), .keyErr(keyErr), .busy(busy),
        .newData(newData), .readData(readData), .plain(plain), .key(key),
        .doneData(doneData), .doneKey(doneKey), .cipher(cipher)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int to_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- SIMON32/64 reference ----------------
    function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [31:0] simon32(input logic [31:0] pt, input logic [63:0] k);
        logic [61:0] z;
        logic [15:0] ks [T];
        logic [15:0] x, y, tmp;
        z = 62'b01100111000011010100100010111110110011100001101010010001011111;
        for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
        for (int i = 4; i < T; i++) begin
            tmp = rol16(ks[i-1], 13) ^ ks[i-3];
            tmp = tmp ^ rol16(tmp, 15);
            ks[i] = ~ks[i-4] ^ tmp ^ {15'd0, z[(i-4) % 62]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < T; i++) begin
            tmp = x;
            x = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ ks[i];
            y = tmp;
        end
        return {x, y};
    endfunction

    // ---------------- core model ----------------
    // newData sampled at edge E: doneKey set, doneData cleared clr_delay edges
    // later, and doneData/cipher presented after edge E+T+2.
    int           clr_delay = 0;
    int           run_left  = 0;
    int           clr_left  = 0;
    logic [63:0]  core_key  = '0;
    logic [31:0]  core_res  = '0;

    initial begin
        logic nd_s;
        logic [31:0] pl_s;
        logic [63:0] ky_s;
        doneData = 1'b0;
        doneKey  = 1'b0;
        cipher   = '0;
        forever begin
            @(negedge clk);
            nd_s = newData;
            pl_s = plain;
            ky_s = key;
            @(posedge clk);
            #1;
            if (!nR) begin
                doneData = 1'b0; doneKey = 1'b0; cipher = '0;
                run_left = 0; clr_left = 0; core_key = '0;
            end else if (nd_s) begin
                if (!doneKey) core_key = ky_s;
                doneKey  = 1'b1;
                core_res = simon32(pl_s, core_key);
                run_left = T + 2;
                clr_left = clr_delay;
                if (clr_delay == 0) doneData = 1'b0;
            end else begin
                if (clr_left > 0) begin
                    clr_left--;
                    if (clr_left == 0) doneData = 1'b0;
                end
                if (run_left > 0) begin
                    run_left--;
                    if (run_left == 0) begin
                        doneData = 1'b1;
                        cipher   = core_res;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int          nd_cnt = 0;
    int          rd_cnt = 0;
    int          ready_viol = 0;
    logic [31:0] seen_plain = '0;
    logic [63:0] seen_key   = '0;

    initial forever begin
        @(negedge clk);
        if (nR === 1'b1) begin
            if (newData) begin
                nd_cnt++;
                seen_plain = plain;
                seen_key   = key;
            end
            if (readData) rd_cnt++;
            if (busy && dinReady) ready_viol++;
        end
    end

    // ---------------- stimulus helpers ----------------
    int last_acc = 0;

    task automatic send_word(input logic is_key, input logic [W-1:0] b);
        int g;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #1;
        dinKey = is_key; din = b; dinValid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!dinReady && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (!dinReady) to_cnt++;
        @(posedge clk);
        #1;
        last_acc = cyc;
        dinValid = 1'b0;
        din = $urandom_range(0, 255);
    endtask

    task automatic load_key(input logic [63:0] k);
        for (int i = 0; i < KW; i++) send_word(1'b1, k[i*W +: W]);
    endtask

    task automatic run_pt(input logic [31:0] pt, input logic [63:0] dut_key,
                          input logic [63:0] ref_key, input int clr_d,
                          input bit bp, input int stall, input string tag,
                          output logic [31:0] got);
        logic [31:0] exp;
        int a, g, idx, hold_bad;
        exp = simon32(pt, ref_key);
        nd_cnt = 0; rd_cnt = 0;
        clr_delay = clr_d;
        doutReady = (stall > 0) ? 1'b0 : 1'b1;
        got = '0;
        for (int i = 0; i < PW; i++) send_word(1'b0, pt[i*W +: W]);
        a = last_acc;
        g = 0;
        @(negedge clk);
        while (!doutValid && g < T + 60) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_latency"}, 64'(cyc - a), 64'(T + 5));
        hold_bad = 0;
        for (int s = 0; s < stall; s++) begin
            if (!doutValid || dout !== exp[W-1:0]) hold_bad++;
            @(negedge clk);
        end
        if (stall > 0) begin
            check({tag, "_stall_hold"}, 64'(hold_bad), 64'd0);
            doutReady = 1'b1;
        end
        idx = 0; g = 0;
        while (idx < PW && g < 300) begin
            if (doutValid && doutReady) begin
                got[idx*W +: W] = dout;
                idx++;
            end
            @(posedge clk);
            #1;
            doutReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            g++;
        end
        check({tag, "_cipher"}, 64'(got), 64'(exp));
        check({tag, "_idle_after"}, {62'd0, busy, doutValid}, 64'd0);
        check({tag, "_newdata_pulses"}, 64'(nd_cnt), 64'd1);
        check({tag, "_readdata_pulses"}, 64'(rd_cnt), 64'd1);
        check({tag, "_plain_to_core"}, 64'(seen_plain), 64'(pt));
        check({tag, "_key_to_core"}, seen_key, dut_key);
    endtask

    // ---------------- main sequence ----------------
    localparam logic [63:0] VEC_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] VEC_PT  = 32'h6565_6877;

    initial begin
        logic [31:0] got;
        logic [63:0] new_key;
        int cnt;
        nR = 1'b0; din = '0; dinKey = 1'b0; dinValid = 1'b0; doutReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {58'd0, busy, dinReady, newData, readData, doutValid, keyErr}, 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_plain", 64'(plain), 64'd0);
        check("rst_key", key, 64'd0);
        @(negedge clk);
        nR = 1'b1;

        // Plaintext offered before any key: must stall without starting.
        @(posedge clk);
        #1;
        dinValid = 1'b1; dinKey = 1'b0; din = 8'h77;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (dinReady || busy) cnt++;
        end
        check("pt_before_key_stall", 64'(cnt), 64'd0);
        check("pt_before_key_no_start", 64'(nd_cnt), 64'd0);
        @(posedge clk);
        #1;
        dinValid = 1'b0;

        // Reference vector, first run.
        load_key(VEC_KEY);
        run_pt(VEC_PT, VEC_KEY, VEC_KEY, 0, 1'b0, 0, "vec1", got);
        check("vec1_known_answer", 64'(got), 64'hc69b_e9bb);
        check("vec1_keyerr", 64'(keyErr), 64'd0);

        // Second run, same key, core slow to clear its stale doneData.
        run_pt(32'h0123_4567, VEC_KEY, VEC_KEY, 5, 1'b0, 0, "run2", got);

        // Randomised plaintexts, backpressure and core clear delays.
        for (int r = 0; r < 6; r++)
            run_pt($urandom, VEC_KEY, VEC_KEY, $urandom_range(0, 6), 1'b1, 0, "rand", got);

        // Sink stalls for 20 cycles at the first output word.
        run_pt(VEC_PT, VEC_KEY, VEC_KEY, 0, 1'b0, 20, "stall", got);
        check("stall_known_answer", 64'(got), 64'hc69b_e9bb);

        // Key word after the core stored its schedule: accepted, sticky error.
        new_key = {$urandom, $urandom};
        send_word(1'b1, new_key[W-1:0]);
        check("keyerr_set", 64'(keyErr), 64'd1);
        for (int i = 1; i < KW; i++) send_word(1'b1, new_key[i*W +: W]);
        run_pt(32'hdead_beef, new_key, VEC_KEY, 2, 1'b1, 0, "after_newkey", got);
        check("keyerr_sticky", 64'(keyErr), 64'd1);

        // Reset pulsed during RUN.
        clr_delay = 0;
        for (int i = 0; i < PW; i++) send_word(1'b0, VEC_PT[i*W +: W]);
        repeat (10) @(posedge clk);
        #3;
        nR = 1'b0;
        #1;
        check("midrst_ctrl", {58'd0, busy, dinReady, newData, readData, doutValid, keyErr}, 64'd0);
        check("midrst_data", {dout, plain[23:0], key[31:0]}, 64'd0);
        check("midrst_plain_key", {plain, key[63:32]}, 64'd0);
        repeat (2) @(negedge clk);
        nR = 1'b1;
        @(posedge clk);
        #1;
        dinValid = 1'b1; dinKey = 1'b0; din = 8'h77;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (dinReady || busy) cnt++;
        end
        check("midrst_key_unloaded", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        dinValid = 1'b0;
        load_key(VEC_KEY);
        run_pt(VEC_PT, VEC_KEY, VEC_KEY, 0, 1'b0, 0, "reload", got);
        check("reload_known_answer", 64'(got), 64'hc69b_e9bb);
        check("reload_keyerr", 64'(keyErr), 64'd0);

        check("dinready_outside_idle", 64'(ready_viol), 64'd0);
        check("handshake_timeouts", 64'(to_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simon_stream_if.md
Name: simon_stream_if

Overview:
- Byte-stream front end for the SIMON iterative encryption core.
- Assembles key and plaintext from a narrow valid/ready input stream, then drives the core's newData/readData handshake.
- Captures the ciphertext and serialises it onto a valid/ready output stream.
- Sits directly upstream and downstream of the core. Top level instantiates both with a shared clk/nR.

Parameters:
N, 16, SIMON word size in bits (block = 2N)
M, 4, key words
T, 32, core round count (used only for latency checks; no internal counter depends on it)
W, 8, stream word width; 2N and M*N must be integer multiples of W

Ports:
clk  in  1  clock, rising edge
nR  in  1  asynchronous active-low reset
din  in  W  input stream word
dinKey  in  1  1 = din is a key word, 0 = plaintext word
dinValid  in  1  input word valid
dinReady  out  1  input word accepted when dinValid&dinReady
dout  out  W  output ciphertext word
doutValid  out  1  output word valid
doutReady  in  1  sink accepts dout
keyErr  out  1  sticky: key word accepted after the core latched its key schedule
busy  out  1  high in every state except IDLE
newData  out  1  to core: start request
readData  out  1  to core: result consumed
plain  out  2N  to core: plaintext
key  out  M*N  to core: key, key[0] = first round key
doneData  in  1  from core: cipher valid
doneKey  in  1  from core: key schedule stored
cipher  in  2N  from core: ciphertext

Behaviour:
- Reset: async on nR low.
  - All outputs, registers, counters and keyErr go to 0; state = IDLE.
  - keyLoaded = 0.
  - nR is shared with the core, so reset mid-operation aborts both and discards partial data.
- Word packing, little-endian:
  - The i-th accepted key word fills key bits [i*W +: W]. Key uses M*N/W words.
  - The i-th plaintext word fills plain bits [i*W +: W]. Plaintext uses 2N/W words.
  - Ciphertext goes out low word first.
- States: IDLE, ISSUE, ARM, RUN, CAPT, SEND.
- IDLE:
  - dinReady = (dinKey & plainCnt==0) | (~dinKey & keyCnt==0 & keyLoaded).
  - A key word arriving while a plaintext load is partial, or a plaintext word arriving while a key load is partial or before any key is loaded, is stalled (dinReady=0).
  - Completing the last key word: keyCnt wraps to 0 and keyLoaded is set.
  - If doneKey=1 when a key word is accepted, keyErr is set; the core ignores new keys after its first run.
  - Completing the last plaintext word: plainCnt wraps to 0 and the next state is ISSUE.
- ISSUE: newData=1 for exactly one cycle -> ARM. plain and key are held stable from here until the next IDLE.
- ARM: wait until doneData=0, which clears the previous run's stale doneData -> RUN. On the first run after reset this passes on the first cycle.
- RUN: when doneData=1, register cipher -> CAPT.
- CAPT: readData=1 for exactly one cycle -> SEND.
- SEND:
  - doutValid=1, dout = low W bits of the cipher shift register.
  - On doutValid&doutReady: shift right by W and increment outCnt.
  - After the 2N/W-th transfer: outCnt wraps to 0 -> IDLE.
  - doutReady held low stalls indefinitely; dout stays stable.
- newData and readData are never high outside ISSUE and CAPT respectively. dinReady=0 outside IDLE.
- Latency: the first doutValid=1 cycle begins T+5 rising edges after the edge that accepts the last plaintext word, given doutReady irrelevant before SEND. This holds for both first and subsequent runs.
- Back-to-back: a new plaintext may be loaded immediately after the last output transfer. The key is retained; no reload is needed.

Test Plan:
- SIMON32/64 vector, W=8:
  - Stimulus: key bytes 00,01,08,09,10,11,18,19 (key words 1918 1110 0908 0100), then plaintext bytes 77,68,65,65.
  - Required: newData one-cycle pulse, readData one-cycle pulse; dout bytes bb,e9,9b,c6 (0xc69be9bb); first doutValid exactly T+5 edges after the last plaintext accept; keyErr=0.
- Second plaintext with the same key, no reload:
  - Required: ARM holds until the core clears doneData; correct cipher; same latency; readData pulses once per run.
- Plaintext before any key:
  - Stimulus: dinValid=1, dinKey=0 after reset.
  - Required: dinReady=0, busy=0, newData never asserted.
- Key word sent after the first run completes:
  - Required: accepted, keyErr=1 and stays 1 until reset.
- doutReady=0 for 20 cycles in SEND:
  - Required: doutValid=1 and dout=bb held stable; then full in-order drain.
- nR pulsed low during RUN:
  - Required: all outputs 0 immediately; state IDLE; keyLoaded=0; a full reload then produces the correct 0xc69be9bb.
